// File: rtl/lpm_pkg.sv
// Shared definitions for the LPM scheduler family: id-width helper and
// output-stage state encoding.
package lpm_pkg;

  // Bits needed to index n items; never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    LPM_EMPTY = 1'b0,
    LPM_FULL  = 1'b1
  } lpm_state_t;

endpackage

// File: rtl/lpm_inv.sv
// Bitwise inverter datapath shared by the LPM schedulers.
module lpm_inv #(
  parameter int lpm_width = 8
) (
  input  logic [lpm_width-1:0] data,
  output logic [lpm_width-1:0] result
);

  assign result = ~data;

endmodule

// File: rtl/lpm_rr_arb.sv
// Combinational round-robin picker: searches req from ptr+1 upward with
// wrap, returns the winner index and a one-hot grant qualified by en.
module lpm_rr_arb
  import lpm_pkg::*;
#(
  parameter int lpm_reqs = 4,
  localparam int ID_W = clog2(lpm_reqs)
) (
  input  logic [lpm_reqs-1:0] req,
  input  logic [ID_W-1:0]     ptr,
  input  logic                en,
  output logic [lpm_reqs-1:0] gnt,
  output logic [ID_W-1:0]     sel
);

  always_comb begin
    logic found;
    int   idx;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    sel   = '0;
    gnt   = '0;
    idx   = 0;
    // Offsets 1..lpm_reqs: the current holder of ptr is checked last.
    for (int k = 1; k <= lpm_reqs; k++) begin
      idx = int'(ptr) + k;
      if (idx >= lpm_reqs) idx = idx - lpm_reqs;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
    if (en && found) gnt[sel] = 1'b1;
  end

endmodule

// File: rtl/lpm_inv_arb.sv
// Round-robin scheduler sharing one lpm_inv among lpm_reqs requesters, with a
// single registered valid/ready output stage tagged by requester index.
module lpm_inv_arb
  import lpm_pkg::*;
#(
  parameter string lpm_type  = "lpm_inv_arb",
  parameter int    lpm_width = 8,
  parameter int    lpm_reqs  = 4,
  parameter string lpm_hint  = "UNUSED",
  localparam int   ID_W      = clog2(lpm_reqs)
) (
  input  logic                          clock,
  input  logic                          aclr_n,
  input  logic [lpm_reqs-1:0]           req,
  input  logic [lpm_reqs*lpm_width-1:0] data,
  output logic [lpm_reqs-1:0]           gnt,
  output logic [lpm_width-1:0]          result,
  output logic [ID_W-1:0]               result_id,
  output logic                          result_valid,
  input  logic                          result_ready
);

  lpm_state_t           state, state_nxt;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      sel;
  logic                 can_load;
  logic                 xfer;
  logic [lpm_width-1:0] op_mux;
  logic [lpm_width-1:0] inv_q;

  assign result_valid = (state == LPM_FULL);
  assign can_load     = !result_valid || result_ready;
  assign xfer         = |gnt;

  // Grants are suppressed while reset is held so no transfer is ever implied.
  lpm_rr_arb #(.lpm_reqs(lpm_reqs)) u_arb (
    .req (req),
    .ptr (ptr),
    .en  (can_load && aclr_n),
    .gnt (gnt),
    .sel (sel)
  );

  always_comb begin
    op_mux = '0;
    for (int i = 0; i < lpm_reqs; i++) begin
      if (sel == ID_W'(i)) op_mux = data[i*lpm_width +: lpm_width];
    end
  end

  lpm_inv #(.lpm_width(lpm_width)) u_inv (
    .data   (op_mux),
    .result (inv_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      LPM_EMPTY: if (xfer) state_nxt = LPM_FULL;
      LPM_FULL:  if (result_ready && !xfer) state_nxt = LPM_EMPTY;
      default:   state_nxt = LPM_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) state <= LPM_EMPTY;
    else         state <= state_nxt;
  end

  // ptr resets to the last index so requester 0 is searched first.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      result    <= '0;
      result_id <= '0;
      ptr       <= ID_W'(lpm_reqs - 1);
    end else if (xfer) begin
      result    <= inv_q;
      result_id <= sel;
      ptr       <= sel;
    end
  end

endmodule

// File: tb/tb_lpm_inv_arb.sv
// Directed self-checking bench for lpm_inv_arb: default 8x4 instance plus a
// 1-bit, 2-requester corner instance.
module tb_lpm_inv_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic        ready = 1'b1;
  logic [3:0]  gnt;
  logic [7:0]  result;
  logic [1:0]  result_id;
  logic        result_valid;

  logic [1:0]  req1 = '0;
  logic [1:0]  data1 = 2'b10;
  logic        ready1 = 1'b1;
  logic [1:0]  gnt1;
  logic [0:0]  result1;
  logic [0:0]  result_id1;
  logic        result_valid1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lpm_inv_arb #(.lpm_width(8), .lpm_reqs(4)) dut (
    .clock        (clk),
    .aclr_n       (rst_n),
    .req          (req),
    .data         (data),
    .gnt          (gnt),
    .result       (result),
    .result_id    (result_id),
    .result_valid (result_valid),
    .result_ready (ready)
  );

  lpm_inv_arb #(.lpm_width(1), .lpm_reqs(2)) dut1 (
    .clock        (clk),
    .aclr_n       (rst_n),
    .req          (req1),
    .data         (data1),
    .gnt          (gnt1),
    .result       (result1),
    .result_id    (result_id1),
    .result_valid (result_valid1),
    .result_ready (ready1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_res;
    int         id;

    // Reset held with all requests high.
    req = 4'b1111;
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(result_valid), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_id", 32'(result_id), 32'h0);
    tick();
    check("rst_gnt_edge", 32'(gnt), 32'h0);
    check("rst_valid_edge", 32'(result_valid), 32'h0);

    // Release with no requests: stays idle.
    rst_n = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    check("idle_valid", 32'(result_valid), 32'h0);
    check("idle_gnt", 32'(gnt), 32'h0);

    // Single request from requester 2.
    data[2*8 +: 8] = 8'h3C;
    req = 4'b0100;
    #1;
    check("single_gnt", 32'(gnt), 32'h4);
    tick();
    req = 4'b0000;
    check("single_result", 32'(result), 32'hC3);
    check("single_id", 32'(result_id), 32'h2);
    check("single_valid", 32'(result_valid), 32'h1);
    tick();
    check("drain_valid", 32'(result_valid), 32'h0);
    check("drain_hold", 32'(result), 32'hC3);

    // Fresh reset so arbitration restarts at requester 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Round-robin with every requester active.
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      id = k % 4;
      exp_res = ~(8'h10 + 8'(id));
      #1;
      check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << id));
      tick();
      check($sformatf("rr_res%0d", k), 32'(result), 32'(exp_res));
      check($sformatf("rr_id%0d", k), 32'(result_id), 32'(id));
      check($sformatf("rr_valid%0d", k), 32'(result_valid), 32'h1);
    end

    // Backpressure: FULL with last result EC / id 3.
    ready = 1'b0;
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_gnt%0d", k), 32'(gnt), 32'h0);
      tick();
      check($sformatf("bp_res%0d", k), 32'(result), 32'hEC);
      check($sformatf("bp_id%0d", k), 32'(result_id), 32'h3);
      check($sformatf("bp_valid%0d", k), 32'(result_valid), 32'h1);
    end
    ready = 1'b1;
    #1;
    check("bp_release_gnt", 32'(gnt), 32'h2);
    check("bp_release_valid", 32'(result_valid), 32'h1);
    tick();
    check("bp_new_res", 32'(result), 32'hEE);
    check("bp_new_id", 32'(result_id), 32'h1);
    check("bp_new_valid", 32'(result_valid), 32'h1);

    // Asynchronous reset mid-cycle while FULL.
    ready = 1'b0;
    req = 4'b1010;
    #3;
    rst_n = 1'b0;
    #1;
    check("amid_valid", 32'(result_valid), 32'h0);
    check("amid_gnt", 32'(gnt), 32'h0);
    check("amid_result", 32'(result), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_gnt", 32'(gnt), 32'h2);
    tick();
    req = 4'b0000;
    check("post_rst_res", 32'(result), 32'hEE);
    check("post_rst_id", 32'(result_id), 32'h1);

    // Corner instance: width 1, two requesters, data = 2'b10.
    req1 = 2'b11;
    #1;
    check("c_gnt0", 32'(gnt1), 32'h1);
    tick();
    check("c_res0", 32'(result1), 32'h1);
    check("c_id0", 32'(result_id1), 32'h0);
    check("c_gnt1", 32'(gnt1), 32'h2);
    tick();
    req1 = 2'b00;
    check("c_res1", 32'(result1), 32'h0);
    check("c_id1", 32'(result_id1), 32'h1);
    check("c_valid1", 32'(result_valid1), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lpm_inv_arb.md
# lpm_inv_arb

Round-robin scheduler that shares one `lpm_inv` inverter datapath among `lpm_reqs` requesters. It accepts at most one operand per cycle, inverts it, and returns the result through a single registered output stage with a valid/ready handshake. The result is tagged with the requester index. It sits between several producer blocks and one downstream consumer wherever a wide inverter is too costly to replicate.

## Interface
- `lpm_type`, default "lpm_inv_arb": LPM type string, informational only.
- `lpm_width`, default 8: operand/result width in bits, range 1..256.
- `lpm_reqs`, default 4: number of requesters, range 2..16.
- `lpm_hint`, default "UNUSED": synthesis hint, ignored.
- `clock`  in  1: single clock, rising edge.
- `aclr_n`  in  1: asynchronous active-low reset; assertion is asynchronous, release is synchronous to `clock` (deasserted by the external reset synchronizer).
- `req`  in  `lpm_reqs`: request per requester; held until granted.
- `data`  in  `lpm_reqs*lpm_width`: operand of requester i at `[i*lpm_width +: lpm_width]`; stable while `req[i]`=1.
- `gnt`  out  `lpm_reqs`: one-hot acceptance, combinational; `req[i]`&`gnt[i]` = transfer this cycle.
- `result`  out  `lpm_width`: registered `~data` of the accepted operand.
- `result_id`  out  `ID_W` = clog2(`lpm_reqs`): index of the requester that produced `result`.
- `result_valid`  out  1: `result` and `result_id` hold valid data.
- `result_ready`  in  1: consumer accepts `result` when high with `result_valid`.

## Operation
- Two-state output stage:
  - EMPTY (`result_valid`=0).
  - FULL (`result_valid`=1).
- Accept condition: `can_load` = !`result_valid` | `result_ready`.
- Arbitration: round-robin over asserted `req` bits, searching from `ptr+1` upward and wrapping at `lpm_reqs-1` to 0. The winner is `sel`.
- `gnt` = onehot(`sel`) when `can_load` and `|req` and `aclr_n`=1; otherwise all zero.
- On a transfer:
  - `result` <= ~`data[sel]`, `result_id` <= `sel`, `result_valid` <= 1.
  - `ptr` <= `sel`.
- FULL with `result_ready`=1 and no request: `result_valid` <= 0; `result`/`result_id` keep their last values.
- FULL with `result_ready`=0: all outputs hold, `gnt`=0, `ptr` holds.
- Simultaneous drain and new transfer: the new result loads in the same edge and `result_valid` stays 1 (no bubble).
- `ptr` changes only on a transfer. A requester that drops `req` before being granted loses nothing; no state is kept per requester.
- Pure bitwise inversion; no width conversion, no carry.

## Timing
- Reset values (asynchronous, while `aclr_n`=0):
  - `result`=0, `result_id`=0, `result_valid`=0.
  - `ptr`=`lpm_reqs-1`, so requester 0 wins first after release.
  - `gnt`=0.
- Latency: `gnt` in cycle N gives `result_valid`=1 with the result after edge N+1.
- Throughput: one result per cycle while `result_ready`=1.
- Fairness: with all `req` held high, each requester is granted exactly once in any `lpm_reqs` consecutive transfers.
- Reset mid-operation: a pending result is discarded and no `gnt` is issued during reset. After release, arbitration restarts at requester 0.
- `gnt` depends combinationally on `req`, `result_valid`, `result_ready` and `ptr`; there is no combinational path from `data` to any output.

## Structure
- Shared package `lpm_pkg`:
  - `clog2` function, used for `ID_W`.
  - `LPM_EMPTY`/`LPM_FULL` state encodings.
- Sub-module `lpm_rr_arb` (parameter `lpm_reqs`; ports `req`, `ptr`, `en` -> `gnt`, `sel`): pure combinational round-robin picker, reusable by other LPM schedulers.
- Datapath: one `lpm_inv` instance fed by the `data` mux output. The output register and `ptr` live in the top level.

## Test plan
- Reset: drive `aclr_n`=0 with `req`=4'b1111 -> `gnt`=0, `result_valid`=0, `result`=0, `result_id`=0. Release with `req`=0 -> stays idle.
- Single request: `req`=4'b0100, `data[2]`=8'h3C, `result_ready`=1 -> `gnt`=4'b0100 in the same cycle; next cycle `result`=8'hC3, `result_id`=2, `result_valid`=1.
- Round-robin: all `req` high, `data[i]`=8'h10+i, `result_ready`=1 -> grants 0,1,2,3,0,... one per cycle; results 8'hEF, 8'hEE, 8'hED, 8'hEC in order with matching ids.
- Backpressure: FULL with `result_ready`=0 for 3 cycles and `req`=4'b0010 -> outputs stable, `gnt`=0. Raise `result_ready` -> old result drains and `gnt`=4'b0010 in the same cycle; `result_valid` never drops.
- Reset mid-operation: assert `aclr_n`=0 asynchronously while FULL and `req`=4'b1010 -> `result_valid`=0 immediately. After release, requester 1 is granted first, since it is the first active request searching from index 0.
- Corner widths: `lpm_width`=1, `lpm_reqs`=2, `data`=2'b10, both requesting -> results 1 (id 0) then 0 (id 1).
